// File: rtl/stack_machine_core.sv
// Stack-machine CPU core: 19-opcode ISA over one request/ack memory port, with data and
// return stacks, depth tracking and fault-halt. While no operand/data access is pending mem_addr shows pc.
module stack_machine_core #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DS_DEPTH = 16,
    parameter int unsigned RS_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_ack,
    output logic [DATA_W-1:0]           out_data,
    output logic                        halted,
    output logic                        fault,
    output logic [2:0]                  fault_code,
    output logic [$clog2(DS_DEPTH):0]   ds_depth
);

    localparam int unsigned DPW = $clog2(DS_DEPTH);
    localparam int unsigned DSW = DPW + 1;
    localparam int unsigned RSW = $clog2(RS_DEPTH) + 1;
    localparam int unsigned RPW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int unsigned SHW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_OPND, S_MRD, S_MWR, S_HALT
    } state_t;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,  OP_LOR = 5'd3,
        OP_XOR = 5'd4,  OP_SHL = 5'd5,  OP_SHR = 5'd6,  OP_SRA = 5'd7,
        OP_DUP = 5'd8,  OP_NUL = 5'd9,  OP_PSI = 5'd10, OP_PSH = 5'd11,
        OP_STR = 5'd12, OP_JPZ = 5'd13, OP_JPN = 5'd14, OP_CAL = 5'd15,
        OP_CAR = 5'd16, OP_RET = 5'd17, OP_FIN = 5'd18
    } opcode_t;

    typedef enum logic [2:0] {
        F_NONE, F_DS_OVF, F_DS_UNF, F_RS_OVF, F_RS_UNF, F_ILLEGAL
    } fault_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [4:0]          ir_q;
    logic [DATA_W-1:0]   ds_q [DS_DEPTH];
    logic [DSW-1:0]      dsd_q;
    logic [ADDR_W-1:0]   rs_q [RS_DEPTH];
    logic [RSW-1:0]      rsd_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                halted_q;
    logic                fault_q;
    logic [2:0]          fault_code_q;

    opcode_t             op;
    fault_t              fault_d;
    logic [DATA_W-1:0]   alu_d;
    logic [DPW-1:0]      ds_push_idx, ds_top_idx, ds_sec_idx;
    logic [RPW-1:0]      rs_push_idx, rs_top_idx;
    logic [DATA_W-1:0]   ds_top, ds_sec;
    logic [SHW-1:0]      shamt;
    logic                ds_full, rs_full, jmp_taken;
    logic [ADDR_W-1:0]   pc_inc1, pc_inc2, mem_target;

    assign op          = opcode_t'(ir_q);
    assign ds_push_idx = dsd_q[DPW-1:0];
    assign ds_top_idx  = dsd_q[DPW-1:0] - DPW'(1);
    assign ds_sec_idx  = dsd_q[DPW-1:0] - DPW'(2);
    assign rs_push_idx = rsd_q[RPW-1:0];
    assign rs_top_idx  = rsd_q[RPW-1:0] - RPW'(1);
    assign ds_top      = ds_q[ds_top_idx];
    assign ds_sec      = ds_q[ds_sec_idx];
    assign shamt       = ds_top[SHW-1:0];
    assign ds_full     = (dsd_q == DSW'(DS_DEPTH));
    assign rs_full     = (rsd_q == RSW'(RS_DEPTH));
    assign jmp_taken   = (op == OP_JPZ) ? (ds_top == '0) : ds_top[DATA_W-1];
    assign pc_inc1     = pc_q + ADDR_W'(1);
    assign pc_inc2     = pc_q + ADDR_W'(2);
    assign mem_target  = ADDR_W'(mem_rdata);

    always_comb begin
        alu_d = '0;
        case (op)
            OP_ADD:  alu_d = ds_sec + ds_top;
            OP_SUB:  alu_d = ds_sec - ds_top;
            OP_AND:  alu_d = ds_sec & ds_top;
            OP_LOR:  alu_d = ds_sec | ds_top;
            OP_XOR:  alu_d = ds_sec ^ ds_top;
            OP_SHL:  alu_d = ds_sec << shamt;
            OP_SHR:  alu_d = ds_sec >> shamt;
            OP_SRA:  alu_d = $unsigned($signed(ds_sec) >>> shamt);
            default: alu_d = '0;
        endcase
    end

    always_comb begin
        fault_d = F_NONE;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_LOR, OP_XOR, OP_SHL, OP_SHR, OP_SRA:
                if (dsd_q < DSW'(2)) fault_d = F_DS_UNF;
            OP_DUP:
                if (dsd_q == '0) fault_d = F_DS_UNF;
                else if (ds_full) fault_d = F_DS_OVF;
            OP_PSI, OP_PSH:
                if (ds_full) fault_d = F_DS_OVF;
            OP_STR, OP_JPZ, OP_JPN, OP_FIN:
                if (dsd_q == '0) fault_d = F_DS_UNF;
            OP_CAL, OP_CAR:
                if (rs_full) fault_d = F_RS_OVF;
            OP_RET:
                if (rsd_q == '0) fault_d = F_RS_UNF;
            OP_NUL:  fault_d = F_NONE;
            default: fault_d = F_ILLEGAL;
        endcase
    end

    // Gated by reset_n so the request drops at once on reset even though the reset state is FETCH.
    assign mem_req   = reset_n && (state_q == S_FETCH || state_q == S_OPND ||
                                   state_q == S_MRD   || state_q == S_MWR);
    assign mem_we    = (state_q == S_MWR);
    assign mem_wdata = (state_q == S_MWR) ? ds_top : '0;

    always_comb begin
        mem_addr = pc_q;
        case (state_q)
            S_OPND:       mem_addr = pc_inc1;
            S_MRD, S_MWR: mem_addr = addr_q;
            default:      mem_addr = pc_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            addr_q       <= '0;
            ir_q         <= '0;
            ds_q         <= '{default: '0};
            dsd_q        <= '0;
            rs_q         <= '{default: '0};
            rsd_q        <= '0;
            out_data_q   <= '0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: if (mem_ack) begin
                    ir_q    <= mem_rdata[4:0];
                    state_q <= S_DECODE;
                end
                S_DECODE: if (fault_d != F_NONE) begin
                    fault_q      <= 1'b1;
                    fault_code_q <= fault_d;
                    halted_q     <= 1'b1;
                    state_q      <= S_HALT;
                end else begin
                    state_q <= S_FETCH;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_LOR, OP_XOR, OP_SHL, OP_SHR, OP_SRA: begin
                            ds_q[ds_sec_idx] <= alu_d;
                            dsd_q            <= dsd_q - DSW'(1);
                            pc_q             <= pc_inc1;
                        end
                        OP_DUP: begin
                            ds_q[ds_push_idx] <= ds_top;
                            dsd_q             <= dsd_q + DSW'(1);
                            pc_q              <= pc_inc1;
                        end
                        OP_NUL: pc_q <= pc_inc1;
                        OP_RET: begin
                            pc_q  <= rs_q[rs_top_idx];
                            rsd_q <= rsd_q - RSW'(1);
                        end
                        OP_JPZ, OP_JPN:
                            if (jmp_taken) state_q <= S_OPND;
                            else pc_q <= pc_inc2;
                        OP_FIN: begin
                            out_data_q <= ds_top;
                            halted_q   <= 1'b1;
                            state_q    <= S_HALT;
                        end
                        default: state_q <= S_OPND;
                    endcase
                end
                S_OPND: if (mem_ack) begin
                    state_q <= S_FETCH;
                    case (op)
                        OP_PSI: begin
                            ds_q[ds_push_idx] <= mem_rdata;
                            dsd_q             <= dsd_q + DSW'(1);
                            pc_q              <= pc_inc2;
                        end
                        OP_PSH: begin
                            addr_q  <= mem_target;
                            state_q <= S_MRD;
                        end
                        OP_STR: begin
                            addr_q  <= mem_target;
                            state_q <= S_MWR;
                        end
                        OP_CAL: begin
                            rs_q[rs_push_idx] <= pc_inc2;
                            rsd_q             <= rsd_q + RSW'(1);
                            pc_q              <= mem_target;
                        end
                        default: pc_q <= mem_target;
                    endcase
                end
                S_MRD: if (mem_ack) begin
                    ds_q[ds_push_idx] <= mem_rdata;
                    dsd_q             <= dsd_q + DSW'(1);
                    pc_q              <= pc_inc2;
                    state_q           <= S_FETCH;
                end
                S_MWR: if (mem_ack) begin
                    dsd_q   <= dsd_q - DSW'(1);
                    pc_q    <= pc_inc2;
                    state_q <= S_FETCH;
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_HALT;
            endcase
        end
    end

    assign out_data   = out_data_q;
    assign halted     = halted_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign ds_depth   = dsd_q;

endmodule
